// File: rtl/seg_scan_drv_pkg.sv
// Shared glyph and anode constants for the multiplexed 7-segment scanner.
// All patterns are active low, bit order {g,f,e,d,c,b,a}.
package seg_scan_drv_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low anode vector with only the selected digit enabled.
    function automatic logic [3:0] an_sel_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_drv_hex7seg_dec.sv
// Combinational hex nibble to active-low 7-segment glyph, zero latency.
module hex7seg_dec
    import seg_scan_drv_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_drv.sv
// 4-digit common-anode scanner: shows A/B or the result, snapshotted once per frame.
// Outputs are registered and change the cycle after each prescaler tick; no backpressure.
module seg_scan_drv
    import seg_scan_drv_pkg::*;
#(
    parameter int DIV = 50000,
    parameter int CW  = 20
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        selout,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    input  logic [15:0] res,
    input  logic        ovf,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [CW-1:0] PCNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] r_pcnt;
    logic [1:0]    r_idx;
    logic          r_sel_q;
    logic [7:0]    r_a_q;
    logic [7:0]    r_b_q;
    logic [15:0]   r_r_q;
    logic          r_ovf_q;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_tick;
    logic          w_frame;
    logic [1:0]    w_idx_nxt;
    logic          w_sel;
    logic [7:0]    w_a;
    logic [7:0]    w_b;
    logic [15:0]   w_r;
    logic          w_ovf;
    logic [3:0]    w_nib;
    logic [6:0]    w_glyph;
    logic [6:0]    w_seg_nxt;
    logic          w_dp_nxt;

    assign w_tick    = (r_pcnt == PCNT_MAX);
    assign w_frame   = w_tick && (r_idx == 2'd3);
    assign w_idx_nxt = r_idx + 2'd1;

    // The first digit of a frame must already use the fresh snapshot,
    // so bypass the snapshot registers on the boundary tick.
    assign w_sel = w_frame ? selout : r_sel_q;
    assign w_a   = w_frame ? op_a   : r_a_q;
    assign w_b   = w_frame ? op_b   : r_b_q;
    assign w_r   = w_frame ? res    : r_r_q;
    assign w_ovf = w_frame ? ovf    : r_ovf_q;

    always_comb begin
        w_nib = 4'h0;
        if (w_sel) begin
            case (w_idx_nxt)
                2'd3: w_nib = w_a[7:4];
                2'd2: w_nib = w_a[3:0];
                2'd1: w_nib = w_b[7:4];
                default: w_nib = w_b[3:0];
            endcase
        end else begin
            case (w_idx_nxt)
                2'd3: w_nib = w_r[15:12];
                2'd2: w_nib = w_r[11:8];
                2'd1: w_nib = w_r[7:4];
                default: w_nib = w_r[3:0];
            endcase
        end
    end

    hex7seg_dec u_dec (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    assign w_seg_nxt = (!w_sel && w_ovf) ? SEG_DASH : w_glyph;
    assign w_dp_nxt  = !(w_sel && (w_idx_nxt == 2'd2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt  <= '0;
            r_idx   <= 2'd3;
            r_sel_q <= 1'b1;
            r_a_q   <= '0;
            r_b_q   <= '0;
            r_r_q   <= '0;
            r_ovf_q <= 1'b0;
            r_an    <= AN_OFF;
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b1;
        end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + CW'(1);
            if (w_tick) begin
                r_idx <= w_idx_nxt;
                r_an  <= an_sel_n(w_idx_nxt);
                r_seg <= w_seg_nxt;
                r_dp  <= w_dp_nxt;
            end
            if (w_frame) begin
                r_sel_q <= selout;
                r_a_q   <= op_a;
                r_b_q   <= op_b;
                r_r_q   <= res;
                r_ovf_q <= ovf;
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
